// File: rtl/i2c_master_xfer_seq.sv
`default_nettype none
// ==========================================================================
// i2c_master_xfer_seq : transaction-level I2C master above a bit controller
// rev 1.0
// ==========================================================================
module i2c_master_xfer_seq #(
  parameter int unsigned LEN_W    = 8,
  parameter logic [2:0]  BIT_IDLE = 3'd0
) (
  input  logic             sysclk,
  input  logic             nReset,
  input  logic             enable,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_addr,
  input  logic [LEN_W-1:0] req_wr_len,
  input  logic [LEN_W-1:0] req_rd_len,
  input  logic             req_nostop,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [7:0]       rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             done,
  output logic             err_nack,
  output logic             err_al,
  output logic             busy,
  output logic [2:0]       bit_cmd,
  output logic             bit_din,
  input  logic             bit_done,
  input  logic             bit_dout,
  input  logic             bit_al
);

  localparam logic [2:0] BIT_START   = 3'd1;
  localparam logic [2:0] BIT_WRITE   = 3'd2;
  localparam logic [2:0] BIT_READ    = 3'd3;
  localparam logic [2:0] BIT_RESTART = 3'd4;
  localparam logic [2:0] BIT_STOP    = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_WR_WAIT, S_WR_BIT, S_WR_ACK,
    S_RESTART, S_RD_BIT, S_RD_HOLD, S_RD_ACK, S_STOP, S_DONE
  } state_t;

  state_t           state;
  logic [6:0]       addr;
  logic             rw;
  logic             nostop;
  logic             hold_bus;
  logic [LEN_W-1:0] wr_cnt;
  logic [LEN_W-1:0] rd_cnt;
  logic [7:0]       shreg;
  logic [2:0]       bitcnt;
  logic             cmd_idle;
  logic             req_rw;
  logic             rx_free;

  assign cmd_idle = (bit_cmd == BIT_IDLE);
  assign req_rw   = (req_wr_len == '0) && (req_rd_len != '0);
  // the rx register is free when empty or being popped this very cycle
  assign rx_free  = !rx_valid || rx_ready;

  always_ff @(posedge sysclk) begin
    if (!nReset || !enable) begin
      state     <= S_IDLE;
      bit_cmd   <= BIT_IDLE;
      bit_din   <= 1'b1;
      req_ready <= 1'b0;
      tx_ready  <= 1'b0;
      rx_data   <= 8'hff;
      rx_valid  <= 1'b0;
      done      <= 1'b0;
      err_nack  <= 1'b0;
      err_al    <= 1'b0;
      busy      <= 1'b0;
      hold_bus  <= 1'b0;
      addr      <= '0;
      rw        <= 1'b0;
      nostop    <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      shreg     <= '0;
      bitcnt    <= '0;
    end else begin
      done     <= 1'b0;
      tx_ready <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (state != S_IDLE && state != S_DONE && bit_al) begin
        bit_cmd  <= BIT_IDLE;
        bit_din  <= 1'b1;
        err_al   <= 1'b1;
        hold_bus <= 1'b0;
        state    <= S_DONE;
      end else begin
        case (state)
          S_IDLE: begin
            req_ready <= 1'b1;
            if (req_valid && req_ready) begin
              addr      <= req_addr;
              wr_cnt    <= req_wr_len;
              rd_cnt    <= req_rd_len;
              nostop    <= req_nostop;
              rw        <= req_rw;
              err_nack  <= 1'b0;
              err_al    <= 1'b0;
              busy      <= 1'b1;
              req_ready <= 1'b0;
              state     <= hold_bus ? S_RESTART : S_START;
            end
          end
          S_START, S_RESTART: begin
            if (cmd_idle) begin
              bit_cmd <= (state == S_START) ? BIT_START : BIT_RESTART;
              bit_din <= 1'b1;
            end else if (bit_done) begin
              bit_cmd <= BIT_IDLE;
              shreg   <= {addr, rw};
              bitcnt  <= '0;
              state   <= S_ADDR;
            end
          end
          S_ADDR, S_WR_BIT: begin
            if (cmd_idle) begin
              bit_cmd <= BIT_WRITE;
              bit_din <= shreg[7];
            end else if (bit_done) begin
              bit_cmd <= BIT_IDLE;
              bit_din <= 1'b1;
              shreg   <= {shreg[6:0], 1'b0};
              bitcnt  <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) state <= (state == S_ADDR) ? S_ADDR_ACK : S_WR_ACK;
            end
          end
          S_ADDR_ACK, S_WR_ACK: begin
            if (cmd_idle) begin
              bit_cmd <= BIT_READ;
              bit_din <= 1'b1;
            end else if (bit_done) begin
              bit_cmd <= BIT_IDLE;
              bitcnt  <= '0;
              if (bit_dout) begin
                err_nack <= 1'b1;
                state    <= S_STOP;
              end else if (state == S_ADDR_ACK) begin
                if (wr_cnt != '0)  state <= S_WR_WAIT;
                else if (rw)       state <= S_RD_BIT;
                else               state <= S_STOP;
              end else begin
                wr_cnt <= wr_cnt - LEN_W'(1);
                if (wr_cnt != LEN_W'(1)) begin
                  state <= S_WR_WAIT;
                end else if (rd_cnt != '0) begin
                  rw    <= 1'b1;
                  state <= S_RESTART;
                end else begin
                  state <= S_STOP;
                end
              end
            end
          end
          S_WR_WAIT: begin
            if (tx_valid) begin
              tx_ready <= 1'b1;
              shreg    <= tx_data;
              bitcnt   <= '0;
              state    <= S_WR_BIT;
            end
          end
          S_RD_BIT: begin
            if (cmd_idle) begin
              bit_cmd <= BIT_READ;
              bit_din <= 1'b1;
            end else if (bit_done) begin
              bit_cmd <= BIT_IDLE;
              shreg   <= {shreg[6:0], bit_dout};
              bitcnt  <= bitcnt + 3'd1;
              if (bitcnt == 3'd7) begin
                if (rx_free) begin
                  rx_data  <= {shreg[6:0], bit_dout};
                  rx_valid <= 1'b1;
                  state    <= S_RD_ACK;
                end else begin
                  state <= S_RD_HOLD;
                end
              end
            end
          end
          S_RD_HOLD: begin
            if (rx_free) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
              state    <= S_RD_ACK;
            end
          end
          S_RD_ACK: begin
            if (cmd_idle) begin
              bit_cmd <= BIT_WRITE;
              bit_din <= (rd_cnt == LEN_W'(1));
            end else if (bit_done) begin
              bit_cmd <= BIT_IDLE;
              bit_din <= 1'b1;
              rd_cnt  <= rd_cnt - LEN_W'(1);
              bitcnt  <= '0;
              state   <= (rd_cnt != LEN_W'(1)) ? S_RD_BIT : S_STOP;
            end
          end
          S_STOP: begin
            // a clean no-stop request keeps the bus; any error releases it
            if (nostop && !err_nack) begin
              hold_bus <= 1'b1;
              state    <= S_DONE;
            end else if (cmd_idle) begin
              bit_cmd <= BIT_STOP;
              bit_din <= 1'b1;
            end else if (bit_done) begin
              bit_cmd  <= BIT_IDLE;
              hold_bus <= 1'b0;
              state    <= S_DONE;
            end
          end
          S_DONE: begin
            done      <= 1'b1;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_xfer_seq.sv
`default_nettype none
// Directed bench for i2c_master_xfer_seq with a bit-controller/slave model.
module tb_i2c_master_xfer_seq;

  logic       sysclk = 1'b0;
  logic       nReset = 1'b0;
  logic       enable = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [6:0] req_addr = '0;
  logic [7:0] req_wr_len = '0;
  logic [7:0] req_rd_len = '0;
  logic       req_nostop = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       done, err_nack, err_al, busy;
  logic [2:0] bit_cmd;
  logic       bit_din;
  logic       bit_done = 1'b0;
  logic       bit_dout = 1'b1;
  logic       bit_al = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [3:0] log_q[$];
  logic [3:0] exp_q[$];
  bit         rdq[$];
  logic [7:0] txq[$];
  logic [7:0] rx_got[$];
  int         al_idx = -1;
  bit         pend = 1'b0;
  int         cnt = 0;
  int         cur_idx = 0;
  logic [2:0] cur_cmd = '0;
  int         done_cnt = 0;
  int         txr_cnt = 0;
  logic       last_nack = 1'b0;
  logic       last_al = 1'b0;

  i2c_master_xfer_seq #(.LEN_W(8), .BIT_IDLE(3'd0)) dut (
    .sysclk(sysclk), .nReset(nReset), .enable(enable),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wr_len(req_wr_len), .req_rd_len(req_rd_len), .req_nostop(req_nostop),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .done(done), .err_nack(err_nack), .err_al(err_al), .busy(busy),
    .bit_cmd(bit_cmd), .bit_din(bit_din), .bit_done(bit_done),
    .bit_dout(bit_dout), .bit_al(bit_al)
  );

  always #5 sysclk = ~sysclk;

  // Bit controller + slave: each command completes 2 cycles after it is seen.
  always @(negedge sysclk) begin
    bit_done = 1'b0;
    bit_al   = 1'b0;
    if (pend) begin
      if (cnt == 0) begin
        pend = 1'b0;
        if (cur_idx == al_idx) begin
          bit_al = 1'b1;
        end else begin
          bit_done = 1'b1;
          if (cur_cmd == 3'd3) bit_dout = (rdq.size() > 0) ? rdq.pop_front() : 1'b0;
        end
      end else begin
        cnt--;
      end
    end else if (bit_cmd != 3'd0) begin
      cur_idx = log_q.size();
      cur_cmd = bit_cmd;
      log_q.push_back({bit_cmd, bit_din});
      pend = 1'b1;
      cnt  = 1;
    end
  end

  // tx producer, rx consumer, done capture
  always @(negedge sysclk) begin
    if (tx_ready) begin
      txr_cnt++;
      if (txq.size() > 0) txq.delete(0);
    end
    tx_valid = (txq.size() > 0);
    tx_data  = (txq.size() > 0) ? txq[0] : 8'h00;
    if (rx_valid && rx_ready) rx_got.push_back(rx_data);
    if (done) begin
      done_cnt++;
      last_nack = err_nack;
      last_al   = err_al;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic send_req(input logic [6:0] a, input logic [7:0] wl, input logic [7:0] rl, input logic ns);
    int i = 0;
    while (!req_ready && i < 200) begin
      tick();
      i++;
    end
    req_addr = a; req_wr_len = wl; req_rd_len = rl; req_nostop = ns;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int start = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic void e_cmd(input logic [2:0] c, input logic d);
    exp_q.push_back({c, d});
  endfunction

  function automatic void e_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back({3'd2, b[i]});
  endfunction

  function automatic void e_reads(input int n);
    repeat (n) exp_q.push_back({3'd3, 1'b1});
  endfunction

  function automatic void s_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) rdq.push_back(b[i]);
  endfunction

  function automatic void clear_all();
    log_q.delete(); exp_q.delete(); rdq.delete(); rx_got.delete();
  endfunction

  task automatic test_reset();
    nReset = 1'b0;
    tick(3);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", req_ready); end
    checks++; if (rx_data !== 8'hff) begin errors++; $display("FAIL rst_rx_data got %h exp ff", rx_data); end
    checks++; if (bit_din !== 1'b1) begin errors++; $display("FAIL rst_bit_din got %b exp 1", bit_din); end
    checks++; if ({tx_ready, rx_valid, done, err_nack, err_al, busy, bit_cmd} !== 9'd0) begin
      errors++; $display("FAIL rst_outputs got %b exp 0", {tx_ready, rx_valid, done, err_nack, err_al, busy, bit_cmd});
    end
    nReset = 1'b1;
    tick(2);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready_after got %b exp 1", req_ready); end
  endtask

  task automatic test_write2();
    bit ok;
    int t0 = txr_cnt;
    clear_all();
    txq.push_back(8'hA5); txq.push_back(8'h3C);
    e_cmd(3'd1, 1'b1); e_byte(8'hA0); e_reads(1); e_byte(8'hA5); e_reads(1);
    e_byte(8'h3C); e_reads(1); e_cmd(3'd5, 1'b1);
    send_req(7'h50, 8'd2, 8'd0, 1'b0);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wr2_done timeout got 0 exp 1"); end
    checks++; if (log_q.size() != exp_q.size()) begin errors++; $display("FAIL wr2_len got %0d exp %0d", log_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++; if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL wr2_seq[%0d] got %h exp %h", i, log_q[i], exp_q[i]); end
    end
    checks++; if (txr_cnt - t0 != 2) begin errors++; $display("FAIL wr2_tx_ready got %0d exp 2", txr_cnt - t0); end
    checks++; if ({last_nack, last_al} !== 2'b00) begin errors++; $display("FAIL wr2_err got %b exp 00", {last_nack, last_al}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr2_busy got %b exp 0", busy); end
  endtask

  task automatic test_combined();
    bit ok;
    clear_all();
    txq.push_back(8'h10);
    rdq.push_back(1'b0); rdq.push_back(1'b0); rdq.push_back(1'b0);
    s_byte(8'h11); s_byte(8'h22);
    e_cmd(3'd1, 1'b1); e_byte(8'hA0); e_reads(1); e_byte(8'h10); e_reads(1);
    e_cmd(3'd4, 1'b1); e_byte(8'hA1); e_reads(1);
    e_reads(8); e_cmd(3'd2, 1'b0); e_reads(8); e_cmd(3'd2, 1'b1); e_cmd(3'd5, 1'b1);
    send_req(7'h50, 8'd1, 8'd2, 1'b0);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL comb_done timeout got 0 exp 1"); end
    checks++; if (log_q.size() != exp_q.size()) begin errors++; $display("FAIL comb_len got %0d exp %0d", log_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++; if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL comb_seq[%0d] got %h exp %h", i, log_q[i], exp_q[i]); end
    end
    checks++; if (rx_got.size() != 2) begin errors++; $display("FAIL comb_rx_cnt got %0d exp 2", rx_got.size()); end
    checks++; if (rx_got.size() == 2 && {rx_got[0], rx_got[1]} !== 16'h1122) begin
      errors++; $display("FAIL comb_rx_data got %h%h exp 1122", rx_got[0], rx_got[1]);
    end
    checks++; if ({last_nack, last_al} !== 2'b00) begin errors++; $display("FAIL comb_err got %b exp 00", {last_nack, last_al}); end
  endtask

  task automatic test_addr_nack();
    bit ok;
    int t0 = txr_cnt;
    clear_all();
    txq.push_back(8'h99);
    rdq.push_back(1'b1);
    e_cmd(3'd1, 1'b1); e_byte(8'hA0); e_reads(1); e_cmd(3'd5, 1'b1);
    send_req(7'h50, 8'd1, 8'd0, 1'b0);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL nack_done timeout got 0 exp 1"); end
    checks++; if (log_q.size() != exp_q.size()) begin errors++; $display("FAIL nack_len got %0d exp %0d", log_q.size(), exp_q.size()); end
    foreach (exp_q[i]) begin
      checks++; if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL nack_seq[%0d] got %h exp %h", i, log_q[i], exp_q[i]); end
    end
    checks++; if (last_nack !== 1'b1) begin errors++; $display("FAIL nack_err got %b exp 1", last_nack); end
    checks++; if (txr_cnt != t0) begin errors++; $display("FAIL nack_tx_ready got %0d exp 0", txr_cnt - t0); end
    txq.delete();
    tick(2);
  endtask

  task automatic test_rx_backpressure();
    bit ok;
    int n0;
    int i = 0;
    clear_all();
    rx_ready = 1'b0;
    rdq.push_back(1'b0);
    s_byte(8'h81); s_byte(8'h42); s_byte(8'hC3);
    e_cmd(3'd1, 1'b1); e_byte(8'hA1); e_reads(1);
    e_reads(8); e_cmd(3'd2, 1'b0); e_reads(8); e_cmd(3'd2, 1'b0); e_reads(8); e_cmd(3'd2, 1'b1);
    e_cmd(3'd5, 1'b1);
    send_req(7'h50, 8'd0, 8'd3, 1'b0);
    while (!rx_valid && i < 1000) begin
      tick();
      i++;
    end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL bp_first_byte timeout got %b exp 1", rx_valid); end
    n0 = log_q.size();
    tick(50);
    checks++; if (log_q.size() != n0 + 9) begin errors++; $display("FAIL bp_stall_cmds got %0d exp %0d", log_q.size(), n0 + 9); end
    checks++; if (bit_cmd !== 3'd0) begin errors++; $display("FAIL bp_stall_cmd got %0d exp 0", bit_cmd); end
    checks++; if (rx_data !== 8'h81) begin errors++; $display("FAIL bp_held_data got %h exp 81", rx_data); end
    rx_ready = 1'b1;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_done timeout got 0 exp 1"); end
    checks++; if (log_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_len got %0d exp %0d", log_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      checks++; if (log_q[k] !== exp_q[k]) begin errors++; $display("FAIL bp_seq[%0d] got %h exp %h", k, log_q[k], exp_q[k]); end
    end
    checks++; if (rx_got.size() != 3) begin errors++; $display("FAIL bp_rx_cnt got %0d exp 3", rx_got.size()); end
    checks++; if (rx_got.size() == 3 && {rx_got[0], rx_got[1], rx_got[2]} !== 24'h8142C3) begin
      errors++; $display("FAIL bp_rx_data got %h%h%h exp 8142c3", rx_got[0], rx_got[1], rx_got[2]);
    end
  endtask

  task automatic test_arb_loss();
    bit ok;
    int i = 0;
    clear_all();
    txq.push_back(8'h5A);
    al_idx = 12;
    e_cmd(3'd1, 1'b1); e_byte(8'hA0); e_reads(1);
    e_cmd(3'd2, 1'b0); e_cmd(3'd2, 1'b1); e_cmd(3'd2, 1'b0);
    send_req(7'h50, 8'd1, 8'd0, 1'b0);
    while (!bit_al && i < 1000) begin
      tick();
      i++;
    end
    checks++; if (bit_al !== 1'b1) begin errors++; $display("FAIL al_seen timeout got %b exp 1", bit_al); end
    checks++; if (bit_cmd !== 3'd0) begin errors++; $display("FAIL al_cmd_idle got %0d exp 0", bit_cmd); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL al_done timeout got 0 exp 1"); end
    checks++; if ({last_al, last_nack} !== 2'b10) begin errors++; $display("FAIL al_err got %b exp 10", {last_al, last_nack}); end
    tick(4);
    checks++; if (log_q.size() != exp_q.size()) begin errors++; $display("FAIL al_len got %0d exp %0d", log_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      checks++; if (log_q[k] !== exp_q[k]) begin errors++; $display("FAIL al_seq[%0d] got %h exp %h", k, log_q[k], exp_q[k]); end
    end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL al_req_ready got %b exp 1", req_ready); end
    al_idx = -1;
  endtask

  task automatic test_probe_hold();
    bit ok;
    int d0;
    clear_all();
    e_cmd(3'd1, 1'b1); e_byte(8'hA0); e_reads(1);
    send_req(7'h50, 8'd0, 8'd0, 1'b1);
    wait_done(ok);
    tick(4);
    checks++; if (!ok) begin errors++; $display("FAIL probe_done timeout got 0 exp 1"); end
    checks++; if (log_q.size() != exp_q.size()) begin errors++; $display("FAIL probe_len got %0d exp %0d", log_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      checks++; if (log_q[k] !== exp_q[k]) begin errors++; $display("FAIL probe_seq[%0d] got %h exp %h", k, log_q[k], exp_q[k]); end
    end
    checks++; if ({last_nack, last_al} !== 2'b00) begin errors++; $display("FAIL probe_err got %b exp 00", {last_nack, last_al}); end

    clear_all();
    txq.push_back(8'h77);
    e_cmd(3'd4, 1'b1); e_byte(8'hA0); e_reads(1); e_byte(8'h77); e_reads(1); e_cmd(3'd5, 1'b1);
    send_req(7'h50, 8'd1, 8'd0, 1'b0);
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_done timeout got 0 exp 1"); end
    checks++; if (log_q.size() != exp_q.size()) begin errors++; $display("FAIL hold_len got %0d exp %0d", log_q.size(), exp_q.size()); end
    foreach (exp_q[k]) begin
      checks++; if (log_q[k] !== exp_q[k]) begin errors++; $display("FAIL hold_seq[%0d] got %h exp %h", k, log_q[k], exp_q[k]); end
    end

    clear_all();
    txq.push_back(8'h01);
    send_req(7'h2A, 8'd1, 8'd0, 1'b0);
    tick(10);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b exp 1", busy); end
    d0 = done_cnt;
    nReset = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy_after got %b exp 0", busy); end
    checks++; if ({bit_cmd, bit_din} !== 4'b0001) begin errors++; $display("FAIL mid_bit_if got %b exp 0001", {bit_cmd, bit_din}); end
    nReset = 1'b1;
    tick(20);
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL mid_no_done got %0d exp 0", done_cnt - d0); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_req_ready got %b exp 1", req_ready); end
  endtask

  initial begin
    test_reset();
    test_write2();
    test_combined();
    test_addr_nack();
    test_rx_backpressure();
    test_arb_loss();
    test_probe_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
